// File: rtl/delay_align.sv
// Purpose: measures the skew between a reference and a delayed stream and emits a delay_96 setting.
// Latency: wr_comm/done appear size+win+1 clocks after the edge that samples start.
// Backpressure: none; start is accepted only in IDLE, requests arriving while busy are dropped.
module delay_align #(
  parameter int size = 20,
  parameter int win  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Iref,
  input  logic [31:0] Idly,
  input  logic        start,
  output logic        wr_comm,
  output logic [7:0]  upr,
  output logic        busy,
  output logic        done,
  output logic        fail
);

  localparam int             CW        = $clog2(win + 1);
  localparam logic [7:0]     FILL_LAST = 8'(size - 2);
  localparam logic [7:0]     MEAS_LAST = 8'(win - 1);
  localparam logic [CW-1:0]  WIN_C     = CW'(win);

  typedef enum logic [2:0] {IDLE, FILL, MEASURE, DECIDE, ISSUE} state_t;

  state_t        state, next_state;
  logic [7:0]    ph;
  logic [31:0]   hist [size-1];   // hist[j] is Iref from j+1 cycles earlier
  logic [31:0]   tap  [size];
  logic [CW-1:0] cnt  [size];
  logic          clr, cnt_en, ph_clr;
  logic          found_c, found_q;
  logic [7:0]    idx_c, idx_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state and control decode; busy covers FILL, MEASURE and DECIDE only
  always_comb begin
    next_state = state;
    clr        = 1'b0;
    cnt_en     = 1'b0;
    ph_clr     = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        ph_clr = 1'b1;
        if (start) begin
          clr        = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        busy = 1'b1;
        if (ph == FILL_LAST) begin
          ph_clr     = 1'b1;
          next_state = MEASURE;
        end
      end
      MEASURE: begin
        busy   = 1'b1;
        cnt_en = 1'b1;
        if (ph == MEAS_LAST) begin
          ph_clr     = 1'b1;
          next_state = DECIDE;
        end
      end
      DECIDE: begin
        busy       = 1'b1;
        next_state = ISSUE;
      end
      ISSUE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Phase counter timing FILL and MEASURE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ph <= 8'd0;
    else if (ph_clr) ph <= 8'd0;
    else             ph <= ph + 8'd1;
  end

  // Reference history shifts every cycle regardless of state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < size - 1; j++) hist[j] <= 32'd0;
    end else begin
      hist[0] <= Iref;
      for (int j = 1; j < size - 1; j++) hist[j] <= hist[j-1];
    end
  end

  // Tap view: tap[0] is the live sample, tap[d] the sample d cycles old
  always_comb begin
    tap[0] = Iref;
    for (int d = 1; d < size; d++) tap[d] = hist[d-1];
  end

  // Per-delay match counters, saturating at the window length
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < size; d++) cnt[d] <= '0;
    end else if (clr) begin
      for (int d = 0; d < size; d++) cnt[d] <= '0;
    end else if (cnt_en) begin
      for (int d = 0; d < size; d++)
        if (tap[d] == Idly && cnt[d] != WIN_C) cnt[d] <= cnt[d] + CW'(1);
    end
  end

  // Winner search: scanning downwards leaves the lowest full-score delay
  always_comb begin
    found_c = 1'b0;
    idx_c   = 8'd0;
    for (int d = size - 1; d >= 0; d--) begin
      if (cnt[d] == WIN_C) begin
        found_c = 1'b1;
        idx_c   = 8'(d);
      end
    end
  end

  // Capture the decision once counting is complete
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      found_q <= 1'b0;
      idx_q   <= 8'd0;
    end else if (state == DECIDE) begin
      found_q <= found_c;
      idx_q   <= idx_c;
    end
  end

  // Registered result strobes; upr and fail hold between measurements
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_comm <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
      upr     <= 8'd0;
    end else begin
      wr_comm <= 1'b0;
      done    <= 1'b0;
      if (clr) fail <= 1'b0;
      if (state == ISSUE) begin
        done <= 1'b1;
        if (found_q) begin
          wr_comm <= 1'b1;
          upr     <= idx_q;
        end else begin
          fail <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_delay_align.sv
module tb_delay_align;

  localparam int SIZE = 20;
  localparam int WIN  = 32;
  localparam int NREC = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Iref, Idly;
  logic        start;
  logic        wr_comm, busy, done, fail;
  logic [7:0]  upr;

  delay_align #(.size(SIZE), .win(WIN)) dut (
    .clk(clk), .rst(rst), .Iref(Iref), .Idly(Idly), .start(start),
    .wr_comm(wr_comm), .upr(upr), .busy(busy), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  // Recorded streams indexed by the clock edge that samples them
  logic [31:0] ir [NREC];
  logic [31:0] id [NREC];
  int   edge_n = 0;
  int   mode   = 0;     // 0 ramp, 1 constant zero, 2 random
  int   dly    = 0;
  bit   corrupt = 1'b0;
  logic o_wr, o_busy, o_done, o_fail;
  logic [7:0] o_upr;
  int   total = 0, passed = 0;
  logic [7:0] held_upr = 8'd0;

  typedef struct {
    string      nm;
    int         mode;
    int         dly;
    bit         exp_fail;
    logic [7:0] exp_upr;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
  endtask

  // Advance one edge, sample outputs 1ns later, then drive the next inputs
  task automatic tick();
    int k;
    logic [31:0] v;
    @(posedge clk);
    edge_n++;
    #1;
    o_wr = wr_comm; o_busy = busy; o_done = done; o_fail = fail; o_upr = upr;
    k = edge_n + 1;
    if (k >= NREC) begin
      $display("FAIL record_overflow: edge %0d, limit %0d", k, NREC);
      $fatal(1);
    end
    case (mode)
      0:       v = 32'(k);
      1:       v = 32'd0;
      default: v = $urandom;
    endcase
    ir[k] = v;
    v = (k - dly >= 0) ? ir[k-dly] : 32'd0;
    if (corrupt && $urandom_range(0, 63) == 0) v = v ^ 32'h1;
    id[k] = v;
    Iref  = ir[k];
    Idly  = v;
  endtask

  // Reference: the lowest delay d for which every Idly sample of the window equals Iref d samples earlier
  function automatic void model(input int c, output bit f, output int idx);
    f = 1'b0;
    idx = 0;
    for (int d = SIZE - 1; d >= 0; d--) begin
      bit ok = 1'b1;
      for (int k = c + SIZE; k < c + SIZE + WIN; k++)
        if (id[k] !== ir[k-d]) ok = 1'b0;
      if (ok) begin
        f = 1'b1;
        idx = d;
      end
    end
  endfunction

  task automatic run(input int mode_i, input int dly_i, input bit corrupt_i, input int second_at,
                     input bit use_model, input bit exp_fail_i, input logic [7:0] exp_upr_i,
                     input string nm);
    int c, n_done, n_wr, done_at, idx;
    logic d_busy, d_fail;
    bit ef, f;
    logic [7:0] eu;
    mode = mode_i; dly = dly_i; corrupt = corrupt_i;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = edge_n;
    chk({nm, "_busy_after_start"}, 32'(o_busy), 32'd1);
    n_done = 0; n_wr = 0; done_at = -1; d_busy = 1'b1; d_fail = 1'bx;
    for (int i = 1; i <= SIZE + WIN + 6; i++) begin
      start = (second_at > 0 && i == second_at);
      tick();
      if (o_done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = edge_n;
          d_busy  = o_busy;
          d_fail  = o_fail;
        end
      end
      if (o_wr) n_wr++;
    end
    start = 1'b0;
    if (use_model) begin
      model(c, f, idx);
      ef = !f;
      eu = f ? 8'(idx) : held_upr;
    end else begin
      ef = exp_fail_i;
      eu = exp_upr_i;
    end
    chk({nm, "_done_count"}, 32'(n_done), 32'd1);
    chk({nm, "_done_latency"}, 32'(done_at - c), 32'(SIZE + WIN + 1));
    chk({nm, "_wr_comm_count"}, 32'(n_wr), ef ? 32'd0 : 32'd1);
    chk({nm, "_fail_at_done"}, 32'(d_fail), 32'(ef));
    chk({nm, "_busy_at_done"}, 32'(d_busy), 32'd0);
    chk({nm, "_upr"}, 32'(o_upr), 32'(eu));
    chk({nm, "_fail_held"}, 32'(o_fail), 32'(ef));
    if (!ef) held_upr = eu;
  endtask

  initial begin
    int n_done, n_wr;
    vecs[0] = '{"ramp_d3",   0, 3,  1'b0, 8'd3};
    vecs[1] = '{"ramp_d0",   0, 0,  1'b0, 8'd0};
    vecs[2] = '{"ramp_d19",  0, 19, 1'b0, 8'd19};
    vecs[3] = '{"ramp_d25",  0, 25, 1'b1, 8'd19};
    vecs[4] = '{"const0",    1, 0,  1'b0, 8'd0};
    vecs[5] = '{"const0_d7", 1, 7,  1'b0, 8'd0};
    vecs[6] = '{"ramp_d7",   0, 7,  1'b0, 8'd7};

    for (int i = 0; i < NREC; i++) begin
      ir[i] = 32'd0;
      id[i] = 32'd0;
    end
    rst = 1'b0; start = 1'b0; Iref = 32'd0; Idly = 32'd0;
    #3;
    chk("reset_wr_comm", 32'(wr_comm), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_fail", 32'(fail), 32'd0);
    chk("reset_upr", 32'(upr), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("idle_busy", 32'(o_busy), 32'd0);

    // Table-driven directed vectors
    for (int i = 0; i < 7; i++) begin
      run(vecs[i].mode, vecs[i].dly, 1'b0, 0, 1'b0, vecs[i].exp_fail, vecs[i].exp_upr, vecs[i].nm);
      repeat (2) tick();
    end

    // Reset asserted in the middle of MEASURE
    mode = 0; dly = 3; corrupt = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    chk("midrst_busy_before", 32'(o_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_wr_comm", 32'(wr_comm), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_fail", 32'(fail), 32'd0);
    chk("midrst_upr", 32'(upr), 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    held_upr = 8'd0;
    n_done = 0; n_wr = 0;
    for (int i = 0; i < SIZE + WIN + 10; i++) begin
      tick();
      if (o_done) n_done++;
      if (o_wr) n_wr++;
    end
    chk("midrst_no_done", 32'(n_done), 32'd0);
    chk("midrst_no_wr_comm", 32'(n_wr), 32'd0);
    run(0, 5, 1'b0, 0, 1'b0, 1'b0, 8'd5, "after_rst_d5");
    repeat (2) tick();

    // A second start during FILL must be ignored
    run(0, 4, 1'b0, 10, 1'b0, 1'b0, 8'd4, "restart_ignored");
    repeat (2) tick();

    // Randomized data and delays against the reference model
    for (int r = 0; r < 10; r++) begin
      run(2, $urandom_range(0, SIZE + 2), ($urandom_range(0, 3) == 0), 0, 1'b1, 1'b0, 8'd0, $sformatf("rand%0d", r));
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/delay_align.md
DELAY_ALIGN -- requirements
Module: delay_align

Interface
REQ-001 Parameter size, default 20, meaning: number of candidate delays 0..size-1 (legal 2..255), matching the delay_96 depth.
REQ-002 Parameter win, default 32, meaning: measurement window length in samples (legal 1..255).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 Iref  input  32  reference stream sample, one per clock.
REQ-006 Idly  input  32  delayed stream sample, one per clock.
REQ-007 start  input  1  one-cycle request to measure skew.
REQ-008 wr_comm  output  1  one-cycle command strobe toward a delay_96 instance.
REQ-009 upr  output  8  delay setting, valid whenever wr_comm is high, held afterwards.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 fail  output  1  qualifies done: high if no delay matched; held until next accepted start.

Function
REQ-013 The block SHALL keep a reference history tap[d], d=0..size-1, where tap[0] is the current Iref and tap[d] is Iref from d cycles earlier.
REQ-014 The FSM SHALL have the states IDLE, FILL, MEASURE, DECIDE and ISSUE.
REQ-015 IDLE: start=1 sampled -> FILL; all match counters cleared; fail cleared; start=0 -> stay.
REQ-016 FILL SHALL last exactly size-1 cycles, flushing history, with no counting.
REQ-017 MEASURE SHALL last exactly win cycles; each cycle, for every d, cnt[d] increments when Idly equals tap[d] on all 32 bits.
REQ-018 cnt[d] width: ceil(log2(win+1)) bits; it SHALL never wrap (max value win).
REQ-019 DECIDE (1 cycle): the winner is the lowest d with cnt[d]==win; ties resolve to the lowest d.
REQ-020 With a winner, ISSUE SHALL drive wr_comm=1, done=1, upr=winner for exactly one cycle, then go to IDLE.
REQ-021 With no winner, ISSUE SHALL drive done=1 and fail=1, keep wr_comm=0 and upr unchanged, then go to IDLE.
REQ-022 Latency: wr_comm/done SHALL be high in the cycle starting size+win+1 rising edges after the edge that sampled start (53 for the defaults).
REQ-023 start while busy SHALL be ignored; it is neither queued nor able to restart the measurement.
REQ-024 busy SHALL be low in IDLE and in the ISSUE cycle, and high in FILL, MEASURE and DECIDE.
REQ-025 The history SHALL shift every cycle in every state; Iref/Idly values outside MEASURE have no effect on the result.
REQ-026 The upper bits of upr SHALL be zero; the winner index fits because size<=255.

Reset
REQ-027 While rst=0: state=IDLE, and wr_comm, done, busy, fail, upr, history and all counters =0, asynchronously.
REQ-028 rst asserted mid-operation SHALL abort the measurement without a wr_comm pulse; after release the block waits in IDLE for a new start.
REQ-029 start is ignored in the cycle where rst releases if it is not sampled on a clock edge with rst=1.

Verification
REQ-030 Iref = ramp 1,2,3..., Idly = Iref delayed 3 cycles, start pulse -> wr_comm=1 and upr=3 exactly 53 cycles after start; done=1, fail=0.
REQ-031 Idly = Iref (delay 0) -> upr=0; Idly delayed 19 -> upr=19; each output is a single-cycle wr_comm pulse.
REQ-032 Idly delayed 25 (>size-1) with ramp data -> done=1, fail=1, wr_comm stays 0, and upr keeps its previous value.
REQ-033 Iref = Idly = constant 0 -> every cnt[d]=32, so upr=0 (lowest-index tie-break).
REQ-034 rst pulled low during MEASURE -> all outputs 0 immediately and no wr_comm; a new start after release with delay 5 -> upr=5.
REQ-035 A second start 10 cycles after the first -> ignored; only one done, at cycle 53 of the first start.
